// File: rtl/photocell_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// photocell_pulse_gen_if
//   Groups the photocell inputs and the counter-side pulse/status outputs of
//   photocell_pulse_gen into one bundle.
//   Modports:
//     slave  - the conditioner: takes BackPC/FrontPC, drives Up/Down/Busy/
//              Overrun (and GlitchCnt when GLITCH_CNT_EN is defined)
//     master - the environment: drives the photocells, observes the outputs
//   Optional feature macro: GLITCH_CNT_EN adds GlitchCnt[7:0].
// -----------------------------------------------------------------------------
interface photocell_pulse_gen_if;
    logic       BackPC;   // async, 1 = beam broken (customer entering)
    logic       FrontPC;  // async, 1 = beam broken (customer leaving)
    logic       Up;       // active-low increment pulse, idle 1
    logic       Down;     // active-low decrement pulse, idle 1
    logic       Busy;     // event pending or pulse/gap in progress
    logic       Overrun;  // sticky: an event was dropped
`ifdef GLITCH_CNT_EN
    logic [7:0] GlitchCnt;  // saturating count of rejected glitches

    modport slave  (input  BackPC, FrontPC,
                    output Up, Down, Busy, Overrun, GlitchCnt);
    modport master (output BackPC, FrontPC,
                    input  Up, Down, Busy, Overrun, GlitchCnt);
`else
    modport slave  (input  BackPC, FrontPC,
                    output Up, Down, Busy, Overrun);
    modport master (output BackPC, FrontPC,
                    input  Up, Down, Busy, Overrun);
`endif
endinterface

// File: rtl/photocell_pulse_gen.sv
// -----------------------------------------------------------------------------
// photocell_pulse_gen
//   Conditions the back (enter) and front (leave) queue photocells: 2-flop
//   synchroniser, debounce filter and rising-edge detect per channel, then
//   serialises the events into active-low Up/Down pulses for the downstream
//   up/down counter. Up and Down are never low in the same cycle.
//   Ports:
//     Clk      in  system clock, rising edge
//     Reset    in  synchronous, active-high
//     pc       photocell_pulse_gen_if.slave:
//                BackPC/FrontPC in, Up/Down/Busy/Overrun out
//                (+ GlitchCnt[7:0] out when GLITCH_CNT_EN is defined)
//   Parameters: DEB_CYC (1..15), PULSE_CYC (1..255), GAP_CYC (1..255)
//   Optional feature macro: GLITCH_CNT_EN (saturating rejected-glitch count).
//   Channel index 0 = back/Up, 1 = front/Down.
// -----------------------------------------------------------------------------
module photocell_pulse_gen #(
    parameter int DEB_CYC   = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    photocell_pulse_gen_if.slave  pc
);
    localparam logic [3:0] DEB_LAST   = 4'(DEB_CYC - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, PULSE_UP, PULSE_DN, GAP} state_t;

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d, filt_dly_q;
    logic [1:0][3:0] deb_q, deb_d;
    logic [1:0][1:0] pend_q, pend_d;
    logic [1:0]      abort, ev, grant;
    logic            ov_q, ov_d;
    state_t          state_q, state_d;
    logic [7:0]      cyc_q, cyc_d;
    logic            last_up_q, last_up_d;
    logic            up_q, up_d, dn_q, dn_d;

    // Debounce: a mismatch run reaching DEB_CYC cycles flips the filtered
    // level; a shorter run that ends is an aborted (glitch) run.
    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            filt_d[ch] = filt_q[ch];
            deb_d[ch]  = '0;
            abort[ch]  = 1'b0;
            if (sync2_q[ch] != filt_q[ch]) begin
                if (deb_q[ch] == DEB_LAST) begin
                    filt_d[ch] = ~filt_q[ch];
                end else begin
                    deb_d[ch] = deb_q[ch] + 4'd1;
                end
            end else begin
                abort[ch] = (deb_q[ch] != '0);
            end
        end
    end

    // Event = filtered level newly high (taken from the registered level).
    assign ev = filt_q & ~filt_dly_q;

    // Pending counts: cur + event - grant; event at count 3 without grant is lost.
    always_comb begin
        ov_d = ov_q;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            pend_d[ch] = pend_q[ch];
            if (ev[ch] && !grant[ch]) begin
                if (pend_q[ch] == 2'd3) begin
                    ov_d = 1'b1;
                end else begin
                    pend_d[ch] = pend_q[ch] + 2'd1;
                end
            end else if (!ev[ch] && grant[ch]) begin
                pend_d[ch] = pend_q[ch] - 2'd1;
            end
        end
    end

    // Emitter FSM. The last GAP cycle falls through into the IDLE grant
    // decision so back-to-back pulses are separated by exactly GAP_CYC
    // high cycles; with nothing pending it lands in IDLE as usual.
    always_comb begin
        logic pick;
        state_d   = state_q;
        cyc_d     = cyc_q;
        last_up_d = last_up_q;
        grant     = '0;
        pick      = 1'b0;
        unique case (state_q)
            IDLE: pick = 1'b1;
            PULSE_UP, PULSE_DN: begin
                if (cyc_q == PULSE_LAST) begin
                    state_d = GAP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            GAP: begin
                if (cyc_q == GAP_LAST) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    pick    = 1'b1;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pick) begin
            // Round-robin: Up wins unless it was served last and Down waits.
            if (pend_q[0] != 2'd0 && (pend_q[1] == 2'd0 || !last_up_q)) begin
                grant[0]  = 1'b1;
                state_d   = PULSE_UP;
                cyc_d     = '0;
                last_up_d = 1'b1;
            end else if (pend_q[1] != 2'd0) begin
                grant[1]  = 1'b1;
                state_d   = PULSE_DN;
                cyc_d     = '0;
                last_up_d = 1'b0;
            end
        end
        up_d = (state_d != PULSE_UP);
        dn_d = (state_d != PULSE_DN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            deb_q      <= '0;
            pend_q     <= '0;
            ov_q       <= 1'b0;
            state_q    <= IDLE;
            cyc_q      <= '0;
            last_up_q  <= 1'b0;
            up_q       <= 1'b1;
            dn_q       <= 1'b1;
        end else begin
            sync1_q    <= {pc.FrontPC, pc.BackPC};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            deb_q      <= deb_d;
            pend_q     <= pend_d;
            ov_q       <= ov_d;
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            last_up_q  <= last_up_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    assign pc.Up      = up_q;
    assign pc.Down    = dn_q;
    assign pc.Overrun = ov_q;
    assign pc.Busy    = (state_q != IDLE) | (pend_q[0] != 2'd0) | (pend_q[1] != 2'd0);

`ifdef GLITCH_CNT_EN
    logic [7:0] gc_q, gc_d;
    logic [8:0] gc_sum;

    always_comb begin
        gc_sum = {1'b0, gc_q} + 9'(abort[0]) + 9'(abort[1]);
        gc_d   = gc_sum[8] ? 8'hFF : gc_sum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gc_q <= '0;
        end else begin
            gc_q <= gc_d;
        end
    end

    assign pc.GlitchCnt = gc_q;
`else
    logic unused_abort;
    assign unused_abort = ^abort;
`endif
endmodule
